tiny_dnn_seq: RTL and testbench

- Job sequencer in front of one tiny_dnn_core plus its normalize stage.
- Shares the core's weight RAM port between host weight load/readback and dot-product jobs.
- Per job: clears the FMA accumulator, streams a bfloat16 input vector against a contiguous weight window, drains the FMA pipeline, strobes normalize, and returns the float32 result over a valid/ready handshake.

---
 rtl/tiny_dnn_seq.sv | 159 +++++++++++++++
 tb/tb_tiny_dnn_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tiny_dnn_seq : job sequencer sharing one tiny_dnn_core weight port     |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module tiny_dnn_seq #(
  parameter int F_SIZE = 512,
  parameter int DRAIN  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        start_ready,
  input  logic [$clog2(F_SIZE)-1:0]   base,
  input  logic [$clog2(F_SIZE)-1:0]   len_m1,
  input  logic                        x_valid,
  input  logic [15:0]                 x_data,
  output logic                        x_ready,
  input  logic                        host_wr,
  input  logic                        host_rd,
  input  logic [$clog2(F_SIZE)-1:0]   host_addr,
  input  logic [15:0]                 host_wdata,
  output logic                        host_ack,
  output logic                        host_rvalid,
  output logic [15:0]                 host_rdata,
  output logic                        core_write,
  output logic                        core_read,
  output logic                        core_init,
  output logic                        core_exec,
  output logic [$clog2(F_SIZE)-1:0]   core_a,
  output logic [15:0]                 core_d,
  input  logic [15:0]                 core_w,
  output logic                        norm_en,
  input  logic [31:0]                 nrm_in,
  output logic                        res_valid,
  output logic [31:0]                 res_data,
  input  logic                        res_ready,
  output logic                        busy
);

  localparam int AW = $clog2(F_SIZE);
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          rd_pend_q, rd_pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    rd_pend_d   = 1'b0;
    start_ready = 1'b0;
    x_ready     = 1'b0;
    host_ack    = 1'b0;
    core_write  = 1'b0;
    core_read   = 1'b0;
    core_init   = 1'b0;
    core_exec   = 1'b0;
    core_a      = '0;
    core_d      = '0;
    norm_en     = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    host_rvalid = rd_pend_q;
    host_rdata  = rd_pend_q ? core_w : 16'h0000;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        start_ready = ~host_wr & ~host_rd;
        if (host_wr) begin
          core_write = 1'b1;
          core_a     = host_addr;
          core_d     = host_wdata;
          host_ack   = 1'b1;
        end else if (host_rd) begin
          // Core returns the weight one cycle later; pend flag marks it valid.
          core_read  = 1'b1;
          core_a     = host_addr;
          host_ack   = 1'b1;
          rd_pend_d  = 1'b1;
        end else if (start) begin
          base_d  = base;
          len_d   = len_m1;
          cnt_d   = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        core_init = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        x_ready = 1'b1;
        if (x_valid) begin
          core_exec = 1'b1;
          core_a    = base_q + cnt_q;
          core_d    = x_data;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == len_q) begin
            dcnt_d  = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) state_d = S_NORM;
        else                      dcnt_d  = dcnt_q + 1'b1;
      end
      S_NORM: begin
        norm_en = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // nrm_in only moves on norm_en, so the result holds while stalled.
        res_valid = 1'b1;
        res_data  = nrm_in;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tiny_dnn_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_tiny_dnn_seq : directed bench with a small core/normalize model     |
// | Revision        : 1.0                                                  |
// +------------------------------------------------------------------------+
module tb_tiny_dnn_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_ready;
  logic [8:0]  base, len_m1;
  logic        x_valid, x_ready;
  logic [15:0] x_data;
  logic        host_wr, host_rd, host_ack, host_rvalid;
  logic [8:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        core_write, core_read, core_init, core_exec;
  logic [8:0]  core_a;
  logic [15:0] core_d, core_w;
  logic        norm_en, res_valid, res_ready, busy;
  logic [31:0] nrm_in, res_data;

  int vectors     = 0;
  int miscompares = 0;
  int cyc_n       = 0;
  int exec_n      = 0;
  int last_exec_cyc = 0;
  logic [8:0] exec_addr [$];

  tiny_dnn_seq #(.F_SIZE(512), .DRAIN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .start_ready(start_ready), .base(base), .len_m1(len_m1),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .core_write(core_write), .core_read(core_read), .core_init(core_init),
    .core_exec(core_exec), .core_a(core_a), .core_d(core_d), .core_w(core_w),
    .norm_en(norm_en), .nrm_in(nrm_in),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: weight RAM, one-stage exec pipeline, integer accumulator,
  // normalize register producing float32 of the accumulated sum.
  logic [15:0] wram [0:511];
  logic [15:0] core_w_q = '0, ew_q = '0, ex_q = '0;
  logic        en_q = 1'b0;
  int          acc = 0;
  logic [31:0] nrm_q = '0;
  assign core_w = core_w_q;
  assign nrm_in = nrm_q;

  function automatic int bf2i(input logic [15:0] b);
    int e;
    if (b[14:0] == 15'd0) return 0;
    e = int'(b[14:7]) - 127;
    return ((128 + int'(b[6:0])) << e) >> 7;
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int p;
    int m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++) if (((v >> i) & 1) != 0) p = i;
    m = (v << (23 - p)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  always @(posedge clk) begin
    if (core_write) wram[core_a] <= core_d;
    if (core_read)  core_w_q <= wram[core_a];
    en_q <= core_exec;
    ew_q <= wram[core_a];
    ex_q <= core_d;
    if (core_init)  acc <= 0;
    else if (en_q)  acc <= acc + bf2i(ew_q) * bf2i(ex_q);
    if (norm_en)    nrm_q <= i2f(acc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    chk("excl", 32'(($countones({core_write, core_read, core_exec}) > 1)), 32'd0);
    chk("xrdy", 32'(x_ready && (!busy || core_init || norm_en || res_valid)), 32'd0);
    if (core_exec) begin
      exec_n++;
      last_exec_cyc = cyc_n;
      exec_addr.push_back(core_a);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 32'({busy, x_ready, core_write, core_read, core_init, core_exec,
                  norm_en, res_valid, host_ack, host_rvalid, start_ready}), 32'd1);
    chk({tag, "_a"}, 32'(core_a), 32'd0);
    chk({tag, "_res"}, res_data, 32'd0);
  endtask

  task automatic host_write(input logic [8:0] a, input logic [15:0] d);
    host_wr = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    chk("wr_ack", 32'(host_ack), 32'd1);
    cyc();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [8:0] a, input logic [15:0] exp);
    host_rd = 1'b1; host_addr = a;
    @(negedge clk);
    chk("rd_ack", 32'(host_ack), 32'd1);
    cyc();
    host_rd = 1'b0;
    @(negedge clk);
    chk("rd_valid", 32'(host_rvalid), 32'd1);
    chk("rd_data", 32'(host_rdata), 32'(exp));
    cyc();
  endtask

  task automatic start_job(input logic [8:0] b, input logic [8:0] lm1);
    start = 1'b1; base = b; len_m1 = lm1;
    @(negedge clk);
    chk("start_ready", 32'(start_ready), 32'd1);
    cyc();
    start = 1'b0;
  endtask

  // Entered at the INIT cycle; leaves with the DUT back in IDLE.
  task automatic run_body(input logic [8:0] lm1, input logic [15:0] xv, input bit gaps,
                          input int stall, input bit hw, input logic [31:0] exp_res,
                          input string tag);
    int sent = 0;
    int k = 0;
    int n = 0;
    bit hw_bad = 1'b0;
    bit stab_bad = 1'b0;
    @(negedge clk);
    chk({tag, "_init"}, 32'(core_init), 32'd1);
    exec_n = 0;
    exec_addr.delete();
    cyc();
    if (hw) begin host_wr = 1'b1; host_addr = 9'd100; host_wdata = 16'h1234; end
    while (sent <= int'(lm1) && k < 4000) begin
      x_valid = gaps ? (((k % 4 == 0) || (k % 4 == 3)) && ($urandom_range(0, 2) != 0)) : 1'b1;
      x_data  = xv;
      @(negedge clk);
      if (x_valid && x_ready) sent++;
      if (host_ack) hw_bad = 1'b1;
      k++;
      cyc();
    end
    x_valid = 1'b0;
    x_data  = 16'h0;
    chk({tag, "_sent"}, 32'(sent), 32'(lm1) + 32'd1);
    @(negedge clk);
    while (!res_valid && n < 20) begin
      if (host_ack) hw_bad = 1'b1;
      cyc();
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(cyc_n - last_exec_cyc), 32'd3);
    repeat (stall) begin
      cyc();
      @(negedge clk);
      if (res_data !== exp_res || !res_valid) stab_bad = 1'b1;
      if (host_ack) hw_bad = 1'b1;
    end
    if (stall > 0) chk({tag, "_stable"}, 32'(stab_bad), 32'd0);
    cyc();
    res_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_res"}, res_data, exp_res);
    if (host_ack) hw_bad = 1'b1;
    cyc();
    res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    if (hw) begin
      chk({tag, "_hw_held"}, 32'(hw_bad), 32'd0);
      chk({tag, "_hw_ack"}, 32'(host_ack), 32'd1);
    end
    cyc();
    host_wr = 1'b0;
    chk({tag, "_execs"}, 32'(exec_n), 32'(lm1) + 32'd1);
  endtask

  initial begin
    int bad;
    int wrap_exp [4] = '{510, 511, 0, 1};
    rst_n = 1'b0; start = 1'b0; base = '0; len_m1 = '0;
    x_valid = 1'b0; x_data = '0; host_wr = 1'b0; host_rd = 1'b0;
    host_addr = '0; host_wdata = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic dot product: 4 x (1.0 * 2.0) = 8.0
    for (int i = 0; i < 4; i++) host_write(9'(i), 16'h3F80);
    host_read(9'd3, 16'h3F80);
    start_job(9'd0, 9'd3);
    run_body(9'd3, 16'h4000, 1'b0, 0, 1'b0, 32'h4100_0000, "basic");

    // Address window wrap: 1+2+3+4 = 10.0
    host_write(9'd510, 16'h3F80);
    host_write(9'd511, 16'h4000);
    host_write(9'd0,   16'h4040);
    host_write(9'd1,   16'h4080);
    start_job(9'd510, 9'd3);
    run_body(9'd3, 16'h3F80, 1'b0, 0, 1'b0, 32'h4120_0000, "wrap");
    for (int i = 0; i < 4; i++) chk("wrap_addr", 32'(exec_addr[i]), 32'(wrap_exp[i]));

    // Input gaps and result backpressure
    start_job(9'd510, 9'd3);
    run_body(9'd3, 16'h3F80, 1'b1, 5, 1'b0, 32'h4120_0000, "bp");

    // Host read collides with start: host first, job next cycle; host write held off
    host_rd = 1'b1; host_addr = 9'd2; start = 1'b1; base = 9'd510; len_m1 = 9'd3;
    @(negedge clk);
    chk("arb_ack", 32'(host_ack), 32'd1);
    chk("arb_start_blk", 32'(start_ready), 32'd0);
    chk("arb_core_read", 32'(core_read), 32'd1);
    cyc();
    host_rd = 1'b0;
    @(negedge clk);
    chk("arb_rvalid", 32'(host_rvalid), 32'd1);
    chk("arb_rdata", 32'(host_rdata), 32'h3F80);
    chk("arb_start_rdy", 32'(start_ready), 32'd1);
    cyc();
    start = 1'b0;
    run_body(9'd3, 16'h3F80, 1'b0, 0, 1'b1, 32'h4120_0000, "arb");
    host_read(9'd100, 16'h1234);

    // Reset after two of four elements
    start_job(9'd0, 9'd3);
    cyc();
    x_valid = 1'b1; x_data = 16'h3F80;
    cyc();
    cyc();
    x_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid || busy) bad++;
      cyc();
    end
    chk("rst_quiet", 32'(bad), 32'd0);
    start_job(9'd2, 9'd0);
    run_body(9'd0, 16'h3F80, 1'b0, 0, 1'b0, 32'h3F80_0000, "init_clr");

    // Full-length job starting at 7 wraps the window once
    for (int i = 0; i < 512; i++) host_write(9'(i), 16'h3F80);
    start_job(9'd7, 9'd511);
    run_body(9'd511, 16'h3F80, 1'b0, 0, 1'b0, 32'h4400_0000, "len512");
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (i >= exec_addr.size() || exec_addr[i] !== 9'((7 + i) % 512)) bad++;
    chk("len512_addr", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
